// File: rtl/complex_mul_pkg.sv
// Shared widths, pipeline depth and the valid/last sideband type for the complex multiplier.
package complex_mul_pkg;

   localparam int LATENCY = 5;

   typedef struct packed {
      logic [LATENCY-1:0] vld;
      logic [LATENCY-1:0] last;
   } sideband_t;

   function automatic int full_w(input int a_w, input int b_w);
      return a_w + b_w + 1;
   endfunction

endpackage

// File: rtl/complex_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp to OUT_W signed bits.
// One guard bit above IN_W keeps the rounding add from wrapping.
module complex_round_sat #(
   parameter int IN_W  = 33,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);
   localparam int W  = IN_W + 1;
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [W-1:0] RND   = (SHIFT > 0) ? (W'(1) << RS) : '0;
   localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [W-1:0] rnd;
   logic signed [W-1:0] shf;

   always_comb begin
      rnd  = W'($signed(din)) + RND;
      shf  = rnd >>> SHIFT;
      dout = shf[OUT_W-1:0];
      sat  = 1'b0;
      if (shf > MAX_V) begin
         dout = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shf < MIN_V) begin
         dout = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/complex_mul_pipe.sv
// Pipelined complex multiplier (Gauss 3-mult) with optional conj(B), rounding and saturation.
// Latency 5 cycles; the whole pipe stalls when out_vld is held against out_rdy low.
module complex_mul_pipe
   import complex_mul_pkg::*;
#(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [A_W-1:0]   in_ar,
   input  logic [A_W-1:0]   in_ai,
   input  logic [B_W-1:0]   in_br,
   input  logic [B_W-1:0]   in_bi,
   input  logic             in_conj,
   input  logic             in_last,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [OUT_W-1:0] out_re,
   output logic [OUT_W-1:0] out_im,
   output logic             out_last,
   output logic             out_sat,
   input  logic             sat_clr,
   output logic             sat_sticky
);
   localparam int FULL_W = full_w(A_W, B_W);
   localparam int PROD_W = A_W + B_W + 2;

   sideband_t sb;
   logic      en;

   logic signed [A_W-1:0]    ar1, ai1, ar2, ai2;
   logic signed [B_W:0]      br1, bi1, br2;
   logic signed [B_W:0]      br_x, bi_x, bi_c;
   logic signed [A_W:0]      sa2;
   logic signed [B_W+1:0]    db2, sb2;
   logic signed [PROD_W-1:0] k1, k2, k3;
   logic signed [FULL_W-1:0] re4, im4;
   logic [OUT_W-1:0]         re_rs, im_rs;
   logic                     re_sat, im_sat;
   logic                     sat_in;

   assign en       = !sb.vld[LATENCY-1] | out_rdy;
   assign in_rdy   = en & !rst;
   assign out_vld  = sb.vld[LATENCY-1];
   assign out_last = sb.last[LATENCY-1];

   // conj(B) is formed one bit wider so negating the most negative bi cannot wrap
   assign br_x = (B_W+1)'($signed(in_br));
   assign bi_x = (B_W+1)'($signed(in_bi));
   assign bi_c = in_conj ? -bi_x : bi_x;

   complex_round_sat #(.IN_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_re (
      .din  (re4),
      .dout (re_rs),
      .sat  (re_sat)
   );

   complex_round_sat #(.IN_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_im (
      .din  (im4),
      .dout (im_rs),
      .sat  (im_sat)
   );

   // only real samples may flag saturation; bubbles carry stale data
   assign sat_in = sb.vld[LATENCY-2] & (re_sat | im_sat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb      <= '0;
         ar1     <= '0;
         ai1     <= '0;
         br1     <= '0;
         bi1     <= '0;
         ar2     <= '0;
         ai2     <= '0;
         br2     <= '0;
         sa2     <= '0;
         db2     <= '0;
         sb2     <= '0;
         k1      <= '0;
         k2      <= '0;
         k3      <= '0;
         re4     <= '0;
         im4     <= '0;
         out_re  <= '0;
         out_im  <= '0;
         out_sat <= 1'b0;
      end else if (en) begin
         sb.vld  <= {sb.vld[LATENCY-2:0], in_vld};
         sb.last <= {sb.last[LATENCY-2:0], in_last};
         ar1     <= $signed(in_ar);
         ai1     <= $signed(in_ai);
         br1     <= br_x;
         bi1     <= bi_c;
         sa2     <= (A_W+1)'(ar1) + (A_W+1)'(ai1);
         db2     <= (B_W+2)'(bi1) - (B_W+2)'(br1);
         sb2     <= (B_W+2)'(br1) + (B_W+2)'(bi1);
         ar2     <= ar1;
         ai2     <= ai1;
         br2     <= br1;
         k1      <= PROD_W'(br2) * PROD_W'(sa2);
         k2      <= PROD_W'(ar2) * PROD_W'(db2);
         k3      <= PROD_W'(ai2) * PROD_W'(sb2);
         re4     <= FULL_W'(k1 - k3);
         im4     <= FULL_W'(k1 + k2);
         out_re  <= re_rs;
         out_im  <= im_rs;
         out_sat <= sat_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_sticky <= 1'b0;
      end else if (en && sat_in) begin
         sat_sticky <= 1'b1;
      end else if (sat_clr) begin
         sat_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Directed-vector bench for complex_mul_pipe with default parameters.
module tb_complex_mul_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [15:0] in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0;
   logic        in_conj = 1'b0;
   logic        in_last = 1'b0;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic [15:0] out_re, out_im;
   logic        out_last, out_sat;
   logic        sat_clr = 1'b0;
   logic        sat_sticky;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   complex_mul_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_ar      (in_ar),
      .in_ai      (in_ai),
      .in_br      (in_br),
      .in_bi      (in_bi),
      .in_conj    (in_conj),
      .in_last    (in_last),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_re     (out_re),
      .out_im     (out_im),
      .out_last   (out_last),
      .out_sat    (out_sat),
      .sat_clr    (sat_clr),
      .sat_sticky (sat_sticky)
   );

   typedef struct {
      int ar, ai, br, bi;
      bit conj;
      int er, ei;
      bit es;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: direct four-multiply form, round half up, clamp to 16 bits
   function automatic longint rsat(input longint v, output logic s);
      longint r;
      r = (v + 64'sd16384) >>> 15;
      s = 1'b0;
      if (r > 32767) begin
         r = 32767;
         s = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         s = 1'b1;
      end
      return r;
   endfunction

   task automatic drive(input int ar, input int ai, input int br, input int bi, input bit conj, input bit last);
      in_ar   = 16'(ar);
      in_ai   = 16'(ai);
      in_br   = 16'(br);
      in_bi   = 16'(bi);
      in_conj = conj;
      in_last = last;
   endtask

   task automatic send_vec(input vec_t v, input int idx);
      int n;
      int lat;
      drive(v.ar, v.ai, v.br, v.bi, v.conj, (idx % 2) == 1);
      in_vld = 1'b1;
      n = 0;
      while (!in_rdy && n < 20) begin
         tick();
         n++;
      end
      tick();
      in_vld = 1'b0;
      lat = 1;
      while (!out_vld && lat < 20) begin
         tick();
         lat++;
      end
      check($sformatf("v%0d_latency", idx), lat, 5);
      check($sformatf("v%0d_re", idx), longint'($signed(out_re)), v.er);
      check($sformatf("v%0d_im", idx), longint'($signed(out_im)), v.ei);
      check($sformatf("v%0d_sat", idx), out_sat, v.es);
      check($sformatf("v%0d_last", idx), out_last, (idx % 2));
   endtask

   logic signed [15:0] bar[8], bai[8], bbr[8], bbi[8];
   logic               bconj[8];
   longint             ere[8], eim[8];
   logic               esat[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] p_re, p_im;
      logic        p_last, p_sat, prev_stall, acc, s1, s2;
      longint      bie;
      int          sent, got, extra;

      vecs[0] = '{16384, 16384, 16384, -16384, 1'b0, 16384, 0, 1'b0};
      vecs[1] = '{16384, 16384, 16384, -16384, 1'b1, 0, 16384, 1'b0};
      vecs[2] = '{-32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1};
      vecs[3] = '{32767, 0, 0, -32768, 1'b1, 0, 32767, 1'b0};
      vecs[4] = '{-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0};
      vecs[5] = '{-32768, -32768, -32768, -32768, 1'b0, 0, 32767, 1'b1};
      vecs[6] = '{-32768, -32768, 32767, -32768, 1'b0, -32768, 1, 1'b1};
      vecs[7] = '{1, 0, 16384, 0, 1'b0, 1, 0, 1'b0};
      vecs[8] = '{100, -200, 300, 400, 1'b1, -2, -3, 1'b0};

      // reset state
      #2 rst = 1'b1;
      #10;
      check("rst_out_vld", out_vld, 0);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_sticky", sat_sticky, 0);
      check("rst_out_re", out_re, 0);
      check("rst_out_sat", out_sat, 0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         send_vec(vecs[i], i);
         tick();
      end

      // sticky clear with nothing saturating in flight
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("sticky_clr_after_table", sat_sticky, 0);

      send_vec(vecs[2], 20);
      check("sticky_set", sat_sticky, 1);
      tick();
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check("sticky_cleared", sat_sticky, 0);

      // set and clear in the same cycle: set wins, the held clear then takes effect
      sat_clr = 1'b1;
      send_vec(vecs[6], 21);
      check("sticky_set_wins", sat_sticky, 1);
      tick();
      check("sticky_clear_next", sat_sticky, 0);
      sat_clr = 1'b0;

      // backpressure: 8 back-to-back samples, out_rdy low in cycles 6..8
      for (int k = 0; k < 8; k++) begin
         bar[k]   = 16'($urandom_range(65535));
         bai[k]   = 16'($urandom_range(65535));
         bbr[k]   = 16'($urandom_range(65535));
         bbi[k]   = 16'($urandom_range(65535));
         bconj[k] = 1'($urandom_range(1));
         bie      = bconj[k] ? -longint'(bbi[k]) : longint'(bbi[k]);
         ere[k]   = rsat(longint'(bar[k]) * longint'(bbr[k]) - longint'(bai[k]) * bie, s1);
         eim[k]   = rsat(longint'(bar[k]) * bie + longint'(bai[k]) * longint'(bbr[k]), s2);
         esat[k]  = s1 | s2;
      end
      sent = 0;
      got = 0;
      prev_stall = 1'b0;
      p_re = '0;
      p_im = '0;
      p_last = 1'b0;
      p_sat = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         if (sent < 8) begin
            drive(int'(bar[sent]), int'(bai[sent]), int'(bbr[sent]), int'(bbi[sent]), bconj[sent], sent == 7);
            in_vld = 1'b1;
         end else begin
            in_vld = 1'b0;
         end
         out_rdy = !(cyc >= 6 && cyc <= 8);
         #1;
         if (prev_stall) begin
            check($sformatf("bp_hold_vld_c%0d", cyc), out_vld, 1);
            check($sformatf("bp_hold_re_c%0d", cyc), out_re, p_re);
            check($sformatf("bp_hold_im_c%0d", cyc), out_im, p_im);
            check($sformatf("bp_hold_last_c%0d", cyc), out_last, p_last);
            check($sformatf("bp_hold_sat_c%0d", cyc), out_sat, p_sat);
         end
         if (!out_rdy) check($sformatf("bp_in_rdy_low_c%0d", cyc), in_rdy, 0);
         if (out_vld && out_rdy) begin
            check($sformatf("bp_s%0d_re", got), longint'($signed(out_re)), ere[got]);
            check($sformatf("bp_s%0d_im", got), longint'($signed(out_im)), eim[got]);
            check($sformatf("bp_s%0d_sat", got), out_sat, esat[got]);
            check($sformatf("bp_s%0d_last", got), out_last, got == 7);
            got++;
         end
         prev_stall = out_vld && !out_rdy;
         p_re = out_re;
         p_im = out_im;
         p_last = out_last;
         p_sat = out_sat;
         acc = in_vld && in_rdy;
         @(posedge clk);
         #1;
         if (acc) sent++;
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      check("bp_output_count", got, 8);
      tick();

      // reset mid-stream
      in_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(-32768, -32768, 32767, -32768, 1'b0, 1'b1);
         tick();
      end
      in_vld = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrst_out_vld", out_vld, 0);
      check("midrst_in_rdy", in_rdy, 0);
      check("midrst_out_last", out_last, 0);
      check("midrst_sticky", sat_sticky, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      send_vec(vecs[0], 1);
      tick();
      extra = 0;
      for (int k = 0; k < 15; k++) begin
         if (out_vld) extra++;
         tick();
      end
      check("midrst_extra_outputs", extra, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/complex_mul_pipe.md
Name: complex_mul_pipe

Overview:
Parametrised, fully pipelined complex multiplier: (ar + j·ai) × (br + j·bi), with an optional per-sample conjugate on the B operand. It uses three real multiplies (Gauss form), then rounds, shifts and saturates the result to a programmable output width. Both sides use valid/ready handshakes, so the block tolerates downstream backpressure. It sits in the DSP datapath between sample sources (mixers, FFT twiddle stages) and accumulators or output formatters.

Parameters:
A_W, 16, signed width of ar/ai
B_W, 16, signed width of br/bi
OUT_W, 16, signed width of out_re/out_im
SHIFT, 15, arithmetic right shift applied after rounding (0 = no rounding)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_vld  in  1  input sample valid
in_rdy  out  1  block can accept a sample this cycle
in_ar  in  A_W  real part of A, signed
in_ai  in  A_W  imag part of A, signed
in_br  in  B_W  real part of B, signed
in_bi  in  B_W  imag part of B, signed
in_conj  in  1  1 = use conj(B)
in_last  in  1  sideband tag, passed through aligned with the data
out_vld  out  1  output sample valid
out_rdy  in  1  downstream accepts the output
out_re  out  OUT_W  rounded, saturated real part
out_im  out  OUT_W  rounded, saturated imag part
out_last  out  1  delayed in_last
out_sat  out  1  this sample saturated (re or im)
sat_clr  in  1  synchronous clear of sat_sticky
sat_sticky  out  1  set by any output saturation since the last clear or reset

Behaviour:
- Reset (async, rst=1): all pipeline valid bits, out_vld, out_re, out_im, out_last, out_sat and sat_sticky are cleared to 0 immediately. in_rdy = 0 while rst is high.
- Pipeline enable: en = !out_vld | out_rdy; in_rdy = en & !rst.
  - All stages advance only when en=1. Bubbles are not collapsed.
  - A sample is accepted when in_vld & in_rdy.
- Latency: 5 cycles from acceptance to out_vld with out_rdy held high. Throughput is 1 sample per cycle.
- While out_vld & !out_rdy, every output holds stable.
- S1, register and conjugate:
  - Register the inputs and the tag.
  - bi' = in_conj ? −bi : bi, computed in B_W+1 bits, so −(−2^(B_W−1)) does not overflow.
  - br is sign-extended to B_W+1.
- S2, pre-adds:
  - s_a = ar + ai (A_W+1 bits)
  - d_b = bi' − br (B_W+2 bits)
  - s_b = br + bi' (B_W+2 bits)
  - ar, ai and br are delayed alongside.
- S3, multiplies:
  - k1 = br·s_a
  - k2 = ar·d_b
  - k3 = ai·s_b
  - All are full precision, signed.
- S4, post-adds (FULL_W = A_W+B_W+1 bits; no overflow is possible):
  - re = k1 − k3
  - im = k1 + k2
- S5, round and saturate, per component:
  - If SHIFT>0, add 2^(SHIFT−1) (round half up), then arithmetic shift right by SHIFT.
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - out_sat = (re clamped) | (im clamped).
- sat_sticky:
  - Set on any cycle where out_sat=1 is registered into the output stage.
  - Cleared by sat_clr=1. If set and clear occur in the same cycle, set wins.
- out_last and all valid bits travel through the same enable chain as the data.
- Reset mid-stream: in-flight samples are discarded and never appear after release. The first output after reset is the first sample accepted after release.

Decomposition:
- Package complex_mul_pkg holds:
  - function full_w(a_w, b_w) returning a_w + b_w + 1
  - a typedef for the 5-stage valid/last sideband struct
  - localparam LATENCY = 5
- Sub-module complex_round_sat (params IN_W, OUT_W, SHIFT): combinational round, shift and clamp with a sat flag. It is instantiated twice (re, im), and its results are registered in S5 of complex_mul_pipe.

Test Plan:
All scenarios use the defaults.
1. Basic multiply: ar=16384, ai=16384, br=16384, bi=−16384, conj=0, out_rdy=1 → 5 cycles later out_re=16384, out_im=0, out_sat=0.
2. Conjugate: same operands with in_conj=1 → out_re=0, out_im=16384.
3. Saturation: ar=−32768, ai=0, br=−32768, bi=0 → out_re=32767, out_im=0, out_sat=1, sat_sticky=1. Then pulse sat_clr with no new saturation → sat_sticky=0.
4. Negation corner: ar=32767, ai=0, br=0, bi=−32768, conj=1 → out_re=0, out_im=32767, out_sat=0. Also ar=−1, ai=0, br=16384, bi=0 → out_re=0 (half-up rounding of −0.5 LSB).
5. Backpressure: 8 back-to-back random samples, out_rdy low for cycles 6–8 → in_rdy low during the stall, outputs stable, all 8 results in order matching the reference model, out_last on sample 8 only.
6. Reset mid-stream: accept 3 samples, assert rst for 1 cycle 2 cycles later → out_vld=0 immediately. Release, send 1 sample → exactly one output, 5 cycles after acceptance.
